// File: rtl/jtag_player_pkg.sv
// rtl/jtag_player_pkg.sv - shared state type and program-byte field positions for the JTAG vector player
package jtag_player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOW,
    HIGH,
    WRITE,
    DONE
  } state_t;

  localparam int TMS_BIT  = 0;
  localparam int TDI_BIT  = 1;
  localparam int CAP_BIT  = 2;
  localparam int LAST_BIT = 7;

endpackage

// File: rtl/tck_phase_timer.sv
// rtl/tck_phase_timer.sv - loadable down-counter timing one TCK phase and flagging the TDO sample index
module tck_phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] sample_val,
  output logic             phase_end,
  output logic             sample_hit
);

  logic [CNT_W-1:0] cnt;

  // Load W-1 on phase entry, then count down to 0 on the last cycle of the phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign phase_end  = (cnt == '0);
  // Phase index i corresponds to cnt == W-1-i, so sample_val is precomputed as W-1-D
  assign sample_hit = (cnt == sample_val);

endmodule

// File: rtl/jtag_vector_player.sv
// rtl/jtag_vector_player.sv - JTAG pin sequencer from vector RAM 1 with TDO capture to vector RAM 2; JTAG_PLAYER_TDO_SYNC_EN adds a TDO synchronizer
module jtag_vector_player
  import jtag_player_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_wr,
  input  logic              jtag_rst,
  input  logic [CNT_W-1:0]  tck_width,
  input  logic [CNT_W-1:0]  tdo_delay,
  output logic [ADDR_W-1:0] vector_1_addr,
  input  logic [7:0]        vector_1_rd_data,
  output logic              vector_1_we,
  output logic [7:0]        vector_1_wr_data,
  output logic [ADDR_W-1:0] vector_2_addr,
  output logic              vector_2_we,
  output logic [7:0]        vector_2_wr_data,
  output logic              jtag_tck,
  output logic              jtag_tms,
  output logic              jtag_tdi,
  input  logic              jtag_tdo,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   step_count
);

  localparam int FW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [FW-1:0] FETCH_LAST = FW'(RD_LAT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   steps;
  logic [FW-1:0]     fetch_cnt;
  logic [CNT_W-1:0]  w_m1, s_idx, w_m1_nx, d_nx;
  logic              cap_q, last_q, tms_q, tdi_q, tdo_smp, tdo_in;
  logic              fetch_last, phase_end, sample_hit, timer_load, start;
  logic              unused_bits;

  assign unused_bits = ^vector_1_rd_data[6:3];
  assign fetch_last  = (fetch_cnt == FETCH_LAST);

  // Start-time timing: W-1 floored at 0, D clamped so it always falls inside the high phase
  always_comb begin
    w_m1_nx = (tck_width == '0) ? '0 : tck_width - 1'b1;
    d_nx    = (tdo_delay > w_m1_nx) ? w_m1_nx : tdo_delay;
  end

  // Next state and phase strobes; abort overrides everything
  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    timer_load = 1'b0;
    case (state)
      IDLE:  if (jtag_wr) begin state_nx = FETCH; start = 1'b1; end
      FETCH: if (fetch_last) begin state_nx = LOW; timer_load = 1'b1; end
      LOW:   if (phase_end) begin state_nx = HIGH; timer_load = 1'b1; end
      HIGH:  if (phase_end) state_nx = WRITE;
      WRITE: state_nx = (last_q || addr == '1) ? DONE : FETCH;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (jtag_rst) begin
      state_nx   = IDLE;
      start      = 1'b0;
      timer_load = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  tck_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (jtag_rst),
    .load       (timer_load),
    .load_val   (w_m1),
    .sample_val (s_idx),
    .phase_end  (phase_end),
    .sample_hit (sample_hit)
  );

  // Run bookkeeping: step address, completed-step count, timing latched for the whole run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr  <= '0;
      steps <= '0;
      w_m1  <= '0;
      s_idx <= '0;
    end else if (jtag_rst) begin
      addr <= '0;
    end else if (start) begin
      addr  <= '0;
      steps <= '0;
      w_m1  <= w_m1_nx;
      s_idx <= w_m1_nx - d_nx;
    end else if (state == WRITE) begin
      steps <= steps + 1'b1;
      if (state_nx == FETCH) addr <= addr + 1'b1;
    end
  end

  // Fetch wait counter, program-byte flags and the TDO sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt <= '0;
      cap_q     <= 1'b0;
      last_q    <= 1'b0;
      tdo_smp   <= 1'b0;
    end else begin
      fetch_cnt <= (state == FETCH && !fetch_last) ? fetch_cnt + 1'b1 : '0;
      if (state == FETCH && fetch_last) begin
        cap_q  <= vector_1_rd_data[CAP_BIT];
        last_q <= vector_1_rd_data[LAST_BIT];
      end
      if (state == HIGH && sample_hit) tdo_smp <= tdo_in;
    end
  end

  // TMS/TDI move only on LOW entry and park high whenever the player is not running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tms_q <= 1'b1;
      tdi_q <= 1'b1;
    end else if (state_nx == IDLE || state_nx == DONE) begin
      tms_q <= 1'b1;
      tdi_q <= 1'b1;
    end else if (state == FETCH && state_nx == LOW) begin
      tms_q <= vector_1_rd_data[TMS_BIT];
      tdi_q <= vector_1_rd_data[TDI_BIT];
    end
  end

`ifdef JTAG_PLAYER_TDO_SYNC_EN
  logic [1:0] tdo_sync;

  // Two-flop synchronizer for a TDO return path not timed to clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tdo_sync <= 2'b00;
    else          tdo_sync <= {tdo_sync[0], jtag_tdo};
  end

  assign tdo_in = tdo_sync[1];
`else
  assign tdo_in = jtag_tdo;
`endif

  // The byte register samples data addressed one cycle before FETCH, so the read
  // address sits at 0 in IDLE and already points at the next step during WRITE.
  assign vector_1_addr    = (state == IDLE)  ? '0 :
                            (state == WRITE) ? addr + 1'b1 : addr;
  assign vector_1_we      = 1'b0;
  assign vector_1_wr_data = 8'h00;
  assign vector_2_addr    = addr;
  assign vector_2_we      = (state == WRITE) && !jtag_rst;
  assign vector_2_wr_data = vector_2_we ? {6'b0, cap_q, tdo_smp} : 8'h00;
  assign jtag_tck         = (state == HIGH);
  assign jtag_tms         = tms_q;
  assign jtag_tdi         = tdi_q;
  assign busy             = (state != IDLE) && (state != DONE);
  assign done             = (state == DONE);
  assign step_count       = steps;

endmodule

// File: tb/tb_jtag_vector_player.sv
// tb/tb_jtag_vector_player.sv - table-driven and directed checks of jtag_vector_player
module tb_jtag_vector_player;

  localparam int ADDR_W = 4;
  localparam int RD_LAT = 2;
  localparam int CNT_W  = 32;
`ifdef JTAG_PLAYER_TDO_SYNC_EN
  localparam int TDO_OFF = 2;
`else
  localparam int TDO_OFF = 0;
`endif

  logic clk = 1'b0;
  logic reset_n, jtag_wr, jtag_rst, jtag_tdo;
  logic [CNT_W-1:0] tck_width, tdo_delay;
  logic [ADDR_W-1:0] vector_1_addr, vector_2_addr;
  logic [7:0] vector_1_rd_data, vector_1_wr_data, vector_2_wr_data;
  logic vector_1_we, vector_2_we, jtag_tck, jtag_tms, jtag_tdi, busy, done;
  logic [ADDR_W:0] step_count;
  logic tdo_toggle, tdo_level;

  always #5 clk = ~clk;

  jtag_vector_player #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .jtag_wr(jtag_wr), .jtag_rst(jtag_rst),
    .tck_width(tck_width), .tdo_delay(tdo_delay),
    .vector_1_addr(vector_1_addr), .vector_1_rd_data(vector_1_rd_data),
    .vector_1_we(vector_1_we), .vector_1_wr_data(vector_1_wr_data),
    .vector_2_addr(vector_2_addr), .vector_2_we(vector_2_we), .vector_2_wr_data(vector_2_wr_data),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .busy(busy), .done(done), .step_count(step_count)
  );

  // Vector RAM 1 with a two-cycle read latency
  logic [7:0] mem1 [16];
  logic [ADDR_W-1:0] p0 = '0, p1 = '0;
  always @(posedge clk) begin p0 <= vector_1_addr; p1 <= p0; end
  assign vector_1_rd_data = mem1[p1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TDO pin driver: constant level or toggling every clk
  initial begin
    jtag_tdo = 1'b0;
    forever begin
      @(posedge clk); #1;
      jtag_tdo = tdo_toggle ? ~jtag_tdo : tdo_level;
    end
  end

  // Monitor logs
  int nrise = 0, nw = 0, nhi = 0, ndone = 0, hi_run = 0;
  logic prev_tck = 1'b0;
  int rise_cyc [256];
  logic rise_tms [256], rise_tdi [256], pin_log [64];
  int hi_len [256];
  logic [ADDR_W-1:0] w_addr [256];
  logic [7:0] w_data [256];

  always @(negedge clk) begin
    pin_log[cyc % 64] = jtag_tdo;
    if (jtag_tck && !prev_tck) begin
      rise_cyc[nrise % 256] = cyc; rise_tms[nrise % 256] = jtag_tms; rise_tdi[nrise % 256] = jtag_tdi;
      nrise++;
    end
    if (jtag_tck) hi_run++;
    else if (prev_tck) begin hi_len[nhi % 256] = hi_run; nhi++; hi_run = 0; end
    if (vector_2_we) begin
      w_addr[nw % 256] = vector_2_addr; w_data[nw % 256] = vector_2_wr_data; nw++;
    end
    if (done) ndone++;
    prev_tck = jtag_tck;
  end

  int errors = 0, checks = 0, start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input logic [23:0] prog, input int n, input logic [7:0] fill);
    for (int i = 0; i < 16; i++) mem1[i] = (i < n) ? prog[8*i +: 8] : fill;
  endtask

  task automatic launch(input logic [31:0] w, input logic [31:0] d);
    @(posedge clk); #1;
    tck_width = w; tdo_delay = d; jtag_wr = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    check("busy_before_start", busy, 0);
    @(posedge clk); #1;
    jtag_wr = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget, output int dly);
    int k;
    dly = -1; k = 0;
    while (dly < 0 && k < budget) begin
      if (done === 1'b1) dly = cyc - start_cyc;
      else begin @(negedge clk); k++; end
    end
  endtask

  typedef struct {
    logic [31:0] w, d;
    int n;
    logic [23:0] prog;
    logic tdo;
    int exp_dly, exp_hi;
    logic [2:0] exp_tms, exp_tdi;
    logic [23:0] exp_cap;
  } vec_t;

  vec_t vt [3];

  initial begin
    int dly, nw0, nr0, nh0, nd0;
    logic exp_bit;
    reset_n = 1'b0; jtag_wr = 1'b0; jtag_rst = 1'b0;
    tck_width = 2; tdo_delay = 0; tdo_toggle = 1'b0; tdo_level = 1'b0;
    for (int i = 0; i < 16; i++) mem1[i] = 8'h80;

    vt[0] = '{32'd2, 32'd1, 3, 24'h820601, 1'b1, 22, 2, 3'b001, 3'b110, 24'h010301};
    vt[1] = '{32'd0, 32'd9, 2, 24'h008705, 1'b0, 11, 1, 3'b011, 3'b010, 24'h000202};
    vt[2] = '{32'd3, 32'd5, 2, 24'h008402, 1'b1, 19, 3, 3'b000, 3'b001, 24'h000301};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tck", jtag_tck, 0);
    check("rst_tms", jtag_tms, 1);
    check("rst_tdi", jtag_tdi, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_v2_we", vector_2_we, 0);
    check("rst_v2_data", vector_2_wr_data, 0);
    check("rst_v1_addr", vector_1_addr, 0);
    check("rst_v2_addr", vector_2_addr, 0);
    check("rst_step_count", step_count, 0);
    check("rst_v1_we", vector_1_we, 0);
    @(posedge clk); #1; reset_n = 1'b1;

    for (int v = 0; v < 3; v++) begin
      load_prog(vt[v].prog, vt[v].n, 8'h80);
      tdo_level = vt[v].tdo;
      repeat (2) @(posedge clk);
      nw0 = nw; nr0 = nrise; nh0 = nhi;
      launch(vt[v].w, vt[v].d);
      wait_done(300, dly);
      check($sformatf("v%0d_done_delay", v), dly, vt[v].exp_dly);
      check($sformatf("v%0d_busy_at_done", v), busy, 0);
      check($sformatf("v%0d_step_count", v), step_count, vt[v].n);
      check($sformatf("v%0d_writes", v), nw - nw0, vt[v].n);
      for (int i = 0; i < vt[v].n; i++) begin
        check($sformatf("v%0d_s%0d_addr", v, i), w_addr[nw0 + i], i);
        check($sformatf("v%0d_s%0d_cap", v, i), w_data[nw0 + i], vt[v].exp_cap[8*i +: 8]);
        check($sformatf("v%0d_s%0d_tms", v, i), rise_tms[nr0 + i], vt[v].exp_tms[i]);
        check($sformatf("v%0d_s%0d_tdi", v, i), rise_tdi[nr0 + i], vt[v].exp_tdi[i]);
        check($sformatf("v%0d_s%0d_high_len", v, i), hi_len[nh0 + i], vt[v].exp_hi);
      end
      @(negedge clk);
      check($sformatf("v%0d_idle_tck", v), jtag_tck, 0);
      check($sformatf("v%0d_idle_tms", v), jtag_tms, 1);
      check($sformatf("v%0d_idle_tdi", v), jtag_tdi, 1);
    end

    // Abort during the high phase of step 2
    load_prog(24'h820601, 3, 8'h80);
    tdo_level = 1'b1;
    nw0 = nw; nd0 = ndone;
    launch(2, 1);
    while (cyc < start_cyc + 11) @(negedge clk);
    @(posedge clk); #1; jtag_rst = 1'b1;
    @(negedge clk);
    check("abort_in_high", jtag_tck, 1);
    @(posedge clk); #1; jtag_rst = 1'b0;
    @(negedge clk);
    check("abort_tck", jtag_tck, 0);
    check("abort_tms", jtag_tms, 1);
    check("abort_tdi", jtag_tdi, 1);
    check("abort_busy", busy, 0);
    check("abort_step_count", step_count, 1);
    check("abort_v2_addr", vector_2_addr, 0);
    repeat (30) @(negedge clk);
    check("abort_writes", nw - nw0, 1);
    check("abort_first_write_addr", w_addr[nw0], 0);
    check("abort_no_done", ndone - nd0, 0);

    // Abort and start in the same cycle: no run
    nw0 = nw;
    @(posedge clk); #1; jtag_rst = 1'b1; jtag_wr = 1'b1;
    @(posedge clk); #1; jtag_rst = 1'b0; jtag_wr = 1'b0;
    @(negedge clk);
    check("rst_wins_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("rst_wins_no_writes", nw - nw0, 0);

    // Restart pulse and width change mid-run are ignored
    nw0 = nw; nh0 = nhi;
    launch(2, 1);
    @(posedge clk); #1; jtag_wr = 1'b1; tck_width = 5; tdo_delay = 0;
    @(posedge clk); #1; jtag_wr = 1'b0;
    wait_done(300, dly);
    check("midrun_done_delay", dly, 22);
    check("midrun_step_count", step_count, 3);
    for (int i = 0; i < 3; i++) check($sformatf("midrun_high_len_%0d", i), hi_len[nh0 + i], 2);
    repeat (10) @(negedge clk);
    check("midrun_no_restart", busy, 0);
    check("midrun_writes", nw - nw0, 3);

    // No stop bit: run ends at the last address
    load_prog(24'h0, 0, 8'h00);
    tdo_level = 1'b0;
    nw0 = nw;
    launch(1, 0);
    wait_done(300, dly);
    check("wrap_done_delay", dly, 81);
    check("wrap_step_count", step_count, 16);
    check("wrap_writes", nw - nw0, 16);
    check("wrap_last_addr", w_addr[nw0 + 15], 15);

    // Toggling TDO: capture reflects the pin at sample index D
    load_prog(24'h008404, 2, 8'h80);
    tdo_toggle = 1'b1;
    repeat (4) @(posedge clk);
    nw0 = nw; nr0 = nrise;
    launch(4, 1);
    wait_done(300, dly);
    check("toggle_done_delay", dly, 23);
    for (int i = 0; i < 2; i++) begin
      exp_bit = pin_log[(rise_cyc[nr0 + i] + 1 - TDO_OFF) % 64];
      check($sformatf("toggle_cap_%0d", i), w_data[nw0 + i], {6'b0, 1'b1, exp_bit});
    end
    tdo_toggle = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
